// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA video RAM arbiter.
package cga_pkg;

    localparam int         VRAM_AW     = 19;
    localparam logic [4:0] FB_BASE_DEF = 5'b10111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/isa_strobe_sync.sv
// Two-flop synchroniser for an active-low ISA strobe; resets to the inactive level.
module isa_strobe_sync (
    input  logic clk,
    input  logic reset,
    input  logic strobe_l_i,
    output logic strobe_l_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= strobe_l_i;
            sync_q <= meta_q;
        end
    end

    assign strobe_l_o = sync_q;

endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares the CGA VRAM port between display fetches and CPU cycles in the B8000 window.
// Define CGA_SNOW_EN to let CPU slots pre-empt display fetches (authentic CGA snow).
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter logic [4:0] FB_BASE    = FB_BASE_DEF,
    parameter int         RD_LATENCY = 1,
    parameter logic [7:0] MAX_WAIT   = 8'd63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0]        bus_a,
    input  logic               bus_memr_l,
    input  logic               bus_memw_l,
    input  logic [7:0]         bus_d,
    output logic [7:0]         bus_out,
    output logic               bus_dir,
    output logic               bus_rdy,
    input  logic [4:0]         clk_seq,
    input  logic               isa_op_enable,
    input  logic               disp_read,
    input  logic [VRAM_AW-1:0] disp_addr,
    output logic [VRAM_AW-1:0] ram_a,
    output logic               ram_we_l,
    input  logic [7:0]         ram_d,
    output logic [7:0]         ram_dout,
    output logic               snow,
    output logic               timeout
);

    localparam logic [1:0] ACC_LAST_RD = 2'(RD_LATENCY);

    state_t      state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  acc_cnt_q, acc_cnt_d;
    logic [7:0]  bus_out_q, bus_out_d;
    logic        timeout_q, timeout_d;

    logic memr_s, memw_s;
    logic cs, grant, abort, acc_last, in_acc;

    // Slot timing reaches us through isa_op_enable; the phase count is carried for the interface only.
    logic unused_clk_seq;
    assign unused_clk_seq = ^clk_seq;

    isa_strobe_sync u_sync_memr (
        .clk        (clk),
        .reset      (reset),
        .strobe_l_i (bus_memr_l),
        .strobe_l_o (memr_s)
    );

    isa_strobe_sync u_sync_memw (
        .clk        (clk),
        .reset      (reset),
        .strobe_l_i (bus_memw_l),
        .strobe_l_o (memw_s)
    );

    assign cs       = (bus_a[19:15] == FB_BASE);
    assign abort    = is_wr_q ? memw_s : memr_s;
    assign acc_last = is_wr_q | (acc_cnt_q == ACC_LAST_RD);
    assign in_acc   = (state_q == ACC);

`ifdef CGA_SNOW_EN
    logic contend_q, contend_d;
    assign grant = isa_op_enable;
`else
    assign grant = isa_op_enable & ~disp_read;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            wait_cnt_q <= '0;
            acc_cnt_q  <= '0;
            bus_out_q  <= '0;
            timeout_q  <= 1'b0;
`ifdef CGA_SNOW_EN
            contend_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            wait_cnt_q <= wait_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
            bus_out_q  <= bus_out_d;
            timeout_q  <= timeout_d;
`ifdef CGA_SNOW_EN
            contend_q  <= contend_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        wait_cnt_d = wait_cnt_q;
        acc_cnt_d  = acc_cnt_q;
        bus_out_d  = bus_out_q;
        timeout_d  = 1'b0;
`ifdef CGA_SNOW_EN
        contend_d  = contend_q;
`endif
        case (state_q)
            IDLE: begin
                if ((~memr_s | ~memw_s) & cs) begin
                    addr_d     = bus_a[14:0];
                    wdata_d    = bus_d;
                    is_wr_d    = ~memw_s;
                    wait_cnt_d = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (grant) begin
                    acc_cnt_d = '0;
                    state_d   = ACC;
`ifdef CGA_SNOW_EN
                    contend_d = disp_read;
`endif
                end else begin
                    // Saturating count gives a single timeout pulse per stalled cycle.
                    if (wait_cnt_q != MAX_WAIT) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                    timeout_d = (wait_cnt_q == MAX_WAIT - 8'd1);
                end
            end
            ACC: begin
                if (acc_last) begin
                    if (!is_wr_q) begin
                        bus_out_d = ram_d;
                    end
                    state_d = DONE;
                end else begin
                    acc_cnt_d = acc_cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (memr_s & memw_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_a    = in_acc ? {{(VRAM_AW-15){1'b0}}, addr_q} : disp_addr;
    assign ram_we_l = ~(in_acc & is_wr_q);
    assign ram_dout = (in_acc & is_wr_q) ? wdata_q : 8'h00;
    // Raw strobes pull ready low before the synchronisers see the cycle.
    assign bus_rdy  = ~(cs & (~bus_memr_l | ~bus_memw_l)) | (state_q == DONE);
    assign bus_dir  = (state_q == DONE) & ~is_wr_q;
    assign bus_out  = bus_out_q;
    assign timeout  = timeout_q;

`ifdef CGA_SNOW_EN
    assign snow = in_acc & (disp_read | (contend_q & (acc_cnt_q == 2'd0)));
`else
    assign snow = in_acc & disp_read;
`endif

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter with a transaction-level reference model.
module tb_cga_vram_arbiter;

    localparam int RDL  = 1;
    localparam int MAXW = 63;
`ifdef CGA_SNOW_EN
    localparam bit SNOW = 1'b1;
`else
    localparam bit SNOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] bus_a = '0;
    logic        memr_l = 1'b1;
    logic        memw_l = 1'b1;
    logic [7:0]  bus_d = '0;
    logic [7:0]  bus_out;
    logic        bus_dir, bus_rdy;
    logic [4:0]  clk_seq = '0;
    logic        isa_op_enable = 1'b0;
    logic        disp_read = 1'b0;
    logic [18:0] disp_addr = '0;
    logic [18:0] ram_a;
    logic        ram_we_l;
    logic [7:0]  ram_d = '0;
    logic [7:0]  ram_dout;
    logic        snow, timeout;

    int checks = 0;
    int errors = 0;

    cga_vram_arbiter dut (
        .clk(clk), .reset(reset), .bus_a(bus_a), .bus_memr_l(memr_l), .bus_memw_l(memw_l),
        .bus_d(bus_d), .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy),
        .clk_seq(clk_seq), .isa_op_enable(isa_op_enable), .disp_read(disp_read),
        .disp_addr(disp_addr), .ram_a(ram_a), .ram_we_l(ram_we_l), .ram_d(ram_d),
        .ram_dout(ram_dout), .snow(snow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dflt(input logic [18:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Sequencer: ISA slot at phase 5 of every 8, display fetch at phase 1.
    bit slots_on = 1'b1;
    bit overlap_on = 1'b0;
    int block_left = 0;
    initial forever begin
        @(posedge clk);
        #2;
        clk_seq = clk_seq + 5'd1;
        isa_op_enable = slots_on && (clk_seq[2:0] == 3'd5);
        disp_read = (clk_seq[2:0] == 3'd1) || (overlap_on && clk_seq[2:0] == 3'd6);
        if (isa_op_enable && block_left > 0) begin
            disp_read = 1'b1;
            block_left--;
        end
        disp_addr = {3'b101, 11'h000, clk_seq};
    end

    // External VRAM, one cycle read latency.
    logic [7:0] vmem [logic [18:0]];
    initial forever begin
        @(posedge clk);
        if (ram_we_l === 1'b0) vmem[ram_a] = ram_dout;
        ram_d <= vmem.exists(ram_a) ? vmem[ram_a] : dflt(ram_a);
    end

    // Reference model: one pending CPU transaction, a shadow memory and counted cycles.
    logic m_sr1 = 1'b1, m_sr2 = 1'b1, m_sw1 = 1'b1, m_sw2 = 1'b1;
    bit   m_pending = 1'b0, m_finished = 1'b0, m_wr = 1'b0, m_contend = 1'b0;
    int   m_acc_left = 0, m_acc_total = 0, m_wait_n = 0;
    logic [14:0] m_addr = '0;
    logic [7:0]  m_wdata = '0, m_bus_out = '0;
    logic [7:0]  m_mem [logic [18:0]];

    function automatic logic [7:0] m_lookup(input logic [18:0] a);
        return m_mem.exists(a) ? m_mem[a] : dflt(a);
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_sr1 = 1'b1; m_sr2 = 1'b1; m_sw1 = 1'b1; m_sw2 = 1'b1;
            m_pending = 1'b0; m_finished = 1'b0; m_acc_left = 0; m_bus_out = 8'h00;
            m_wait_n = 0; m_contend = 1'b0;
        end else begin
            if (m_finished) begin
                if (m_sr2 && m_sw2) m_finished = 1'b0;
            end else if (m_acc_left > 0) begin
                m_acc_left--;
                if (m_acc_left == 0) begin
                    if (m_wr) m_mem[{4'h0, m_addr}] = m_wdata;
                    else m_bus_out = m_lookup({4'h0, m_addr});
                    m_finished = 1'b1;
                end
            end else if (m_pending) begin
                if (m_wr ? m_sw2 : m_sr2) begin
                    m_pending = 1'b0;
                end else if (isa_op_enable && (SNOW || !disp_read)) begin
                    m_pending = 1'b0;
                    m_acc_total = m_wr ? 1 : 1 + RDL;
                    m_acc_left = m_acc_total;
                    m_contend = disp_read;
                end else begin
                    m_wait_n++;
                end
            end else if ((!m_sr2 || !m_sw2) && bus_a[19:15] == 5'b10111) begin
                m_pending = 1'b1;
                m_wr = !m_sw2;
                m_addr = bus_a[14:0];
                m_wdata = bus_d;
                m_wait_n = 0;
            end
            m_sr2 = m_sr1; m_sr1 = memr_l;
            m_sw2 = m_sw1; m_sw1 = memw_l;
        end
    end

    int we_cnt = 0, snow_cnt = 0, to_cnt = 0, rdy_low = 0, slot_cnt = 0, slot_at_we = -1;
    logic [18:0] last_we_a = '0;
    logic [7:0]  last_we_d = '0;

    // Every-cycle compare against the model, plus event statistics for directed checks.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            bit accessing;
            logic [18:0] e_a;
            bit e_rdy, e_snow;
            accessing = (m_acc_left > 0);
            e_a = accessing ? {4'h0, m_addr} : disp_addr;
            e_rdy = !((bus_a[19:15] == 5'b10111) && (!memr_l || !memw_l)) || m_finished;
            e_snow = accessing && (disp_read || (SNOW && m_contend && m_acc_left == m_acc_total));
            chk("ram_a", 32'(ram_a), 32'(e_a));
            chk("ram_we_l", 32'(ram_we_l), 32'(!(accessing && m_wr)));
            chk("ram_dout", 32'(ram_dout), 32'((accessing && m_wr) ? m_wdata : 8'h00));
            chk("bus_rdy", 32'(bus_rdy), 32'(e_rdy));
            chk("bus_dir", 32'(bus_dir), 32'(m_finished && !m_wr));
            chk("bus_out", 32'(bus_out), 32'(m_bus_out));
            chk("snow", 32'(snow), 32'(e_snow));
            chk("timeout", 32'(timeout), 32'(m_pending && m_wait_n == MAXW));
            if (isa_op_enable) slot_cnt++;
            if (ram_we_l === 1'b0) begin
                we_cnt++;
                last_we_a = ram_a;
                last_we_d = ram_dout;
                slot_at_we = slot_cnt;
            end
            if (snow) snow_cnt++;
            if (timeout) to_cnt++;
            if (!bus_rdy) rdy_low++;
        end
    end

    task automatic align();
        do @(negedge clk); while (clk_seq[2:0] != 3'd0);
    endtask

    task automatic clear_stats();
        we_cnt = 0; snow_cnt = 0; to_cnt = 0; rdy_low = 0; slot_cnt = 0; slot_at_we = -1;
    endtask

    task automatic wait_rdy(input string nm, input int lim);
        int n = 0;
        while (bus_rdy !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(bus_rdy), 32'h1);
    endtask

    task automatic release_bus();
        memr_l = 1'b1;
        memw_l = 1'b1;
        bus_a = 20'h00000;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bit found;
        repeat (2) @(negedge clk);
        chk("rst_bus_rdy", 32'(bus_rdy), 32'h1);
        chk("rst_bus_dir", 32'(bus_dir), 32'h0);
        chk("rst_bus_out", 32'(bus_out), 32'h00);
        chk("rst_ram_we_l", 32'(ram_we_l), 32'h1);
        chk("rst_ram_dout", 32'(ram_dout), 32'h00);
        chk("rst_snow", 32'(snow), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_ram_a", 32'(ram_a), 32'(disp_addr));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Uncontended write: grant at phase 5, strobe at phase 6, ready at phase 7.
        align(); clear_stats();
        bus_a = 20'hB8010; bus_d = 8'hA5; memw_l = 1'b0;
        @(negedge clk);
        chk("wr_rdy_low", 32'(bus_rdy), 32'h0);
        wait_rdy("wr_rdy", 100);
        chk("wr_rdy_phase", 32'(clk_seq[2:0]), 32'h7);
        chk("wr_we_cnt", 32'(we_cnt), 32'h1);
        chk("wr_ram_a", 32'(last_we_a), 32'h00010);
        chk("wr_ram_dout", 32'(last_we_d), 32'hA5);
        release_bus();

        // Read with one-cycle latency.
        vmem[19'h00123] = 8'h3C;
        m_mem[19'h00123] = 8'h3C;
        align(); clear_stats();
        bus_a = 20'hB8123; memr_l = 1'b0;
        @(negedge clk);
        chk("rd_rdy_low", 32'(bus_rdy), 32'h0);
        wait_rdy("rd_rdy", 100);
        chk("rd_rdy_phase", 32'(clk_seq[2:0]), 32'h0);
        chk("rd_bus_out", 32'(bus_out), 32'h3C);
        chk("rd_bus_dir_done", 32'(bus_dir), 32'h1);
        memr_l = 1'b1; bus_a = 20'h00000;
        repeat (3) @(negedge clk);
        chk("rd_bus_dir_idle", 32'(bus_dir), 32'h0);
        chk("rd_bus_out_held", 32'(bus_out), 32'h3C);
        repeat (2) @(negedge clk);

`ifndef CGA_SNOW_EN
        // Display fetch collides with the first three slots; fourth slot carries the write.
        align(); clear_stats();
        block_left = 3;
        bus_a = 20'hB8200; bus_d = 8'h77; memw_l = 1'b0;
        @(negedge clk);
        wait_rdy("prio_rdy", 200);
        chk("prio_slot", 32'(slot_at_we), 32'h4);
        chk("prio_we_cnt", 32'(we_cnt), 32'h1);
        chk("prio_ram_a", 32'(last_we_a), 32'h00200);
        chk("prio_snow", 32'(snow_cnt), 32'h0);
        release_bus();
`else
        // CPU slot pre-empts the colliding display fetch.
        align(); clear_stats();
        block_left = 1;
        bus_a = 20'hB8200; bus_d = 8'h77; memw_l = 1'b0;
        @(negedge clk);
        wait_rdy("snow_rdy", 200);
        chk("snow_slot", 32'(slot_at_we), 32'h1);
        chk("snow_we_cnt", 32'(we_cnt), 32'h1);
        chk("snow_cnt", 32'(snow_cnt), 32'h1);
        release_bus();
`endif

        // Out-of-window strobe is ignored.
        align(); clear_stats();
        bus_a = 20'hB0000; bus_d = 8'hFF; memw_l = 1'b0;
        repeat (20) @(negedge clk);
        chk("oow_rdy_low", 32'(rdy_low), 32'h0);
        chk("oow_we_cnt", 32'(we_cnt), 32'h0);
        release_bus();

        // Sequencer overlap during the write access.
        overlap_on = 1'b1;
        align(); clear_stats();
        bus_a = 20'hB8060; bus_d = 8'h11; memw_l = 1'b0;
        @(negedge clk);
        wait_rdy("ovl_rdy", 100);
        chk("ovl_snow", 32'(snow_cnt), 32'h1);
        chk("ovl_we_cnt", 32'(we_cnt), 32'h1);
        chk("ovl_data", 32'(last_we_d), 32'h11);
        overlap_on = 1'b0;
        release_bus();

        // Write abandoned while waiting for a slot.
        slots_on = 1'b0;
        align(); clear_stats();
        bus_a = 20'hB8300; bus_d = 8'h22; memw_l = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_rdy_low", 32'(bus_rdy), 32'h0);
        memw_l = 1'b1; bus_a = 20'h00000;
        repeat (4) @(negedge clk);
        slots_on = 1'b1;
        repeat (16) @(negedge clk);
        chk("abort_we_cnt", 32'(we_cnt), 32'h0);

        // Stalled read: one timeout pulse, then completes once slots return.
        slots_on = 1'b0;
        align(); clear_stats();
        bus_a = 20'hB8400; memr_l = 1'b0;
        repeat (100) @(negedge clk);
        chk("to_pulses", 32'(to_cnt), 32'h1);
        chk("to_rdy_low", 32'(bus_rdy), 32'h0);
        slots_on = 1'b1;
        wait_rdy("to_rdy", 40);
        chk("to_bus_out", 32'(bus_out), 32'h5A);
        release_bus();

        // Reset lands in the middle of a write access.
        align(); clear_stats();
        bus_a = 20'hB8050; bus_d = 8'h5A; memw_l = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ram_we_l === 1'b0) found = 1'b1;
        end
        chk("rst_acc_found", 32'(found), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("rst_acc_we_l", 32'(ram_we_l), 32'h1);
        chk("rst_acc_dout", 32'(ram_dout), 32'h00);
        memw_l = 1'b1; bus_a = 20'h00000;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        align(); clear_stats();
        bus_a = 20'hB8050; memr_l = 1'b0;
        @(negedge clk);
        wait_rdy("rst_rb_rdy", 100);
        chk("rst_rb_data", 32'(bus_out), 32'h0A);
        release_bus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
